// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types for the 8-bit accumulator pipeline: ALU opcode
//               encoding, execute-stage FSM states and decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOT   = 4'd5,
    ALU_SHL   = 4'd6,
    ALU_SHR   = 4'd7,
    ALU_PASSB = 4'd8,
    ALU_PASSA = 4'd9,
    ALU_MUL   = 4'd10,
    ALU_DIV   = 4'd11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } ex_state_t;

  // Opcodes that go through the iterative engine instead of the 1-cycle ALU.
  function automatic logic is_mul_div(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIV);
  endfunction

  // Codes 12..15 execute as PASSA but must never write anything.
  function automatic logic is_reserved(input logic [3:0] op);
    return op >= 4'd12;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_iter
// Description : Iterative unsigned engine, one step per clock. MUL uses
//               shift-add (16-bit product in {hi,lo}); DIV uses restoring
//               division (quotient in lo, remainder in hi).
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_iter
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int ITER  = WIDTH            // must equal WIDTH
) (
  input  logic             clk,
  input  logic             rst,          // synchronous, active-low
  input  logic             start,
  input  logic             abort,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dz
);

  localparam int CNT_W = $clog2(ITER) + 1;

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   rshift;
  logic             last;

  // The final iteration is being performed this cycle.
  assign last = run_q && (cnt_q == CNT_W'(ITER - 1));

  // Load on start, then one multiply or divide step per cycle until ITER done.
  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rshift = {hi_q, lo_q[WIDTH-1]};
    if (abort) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      div_d = is_div;
      dz_d  = is_div && (b == '0);
      hi_d  = '0;
      lo_d  = a;
      b_d   = b;
    end else if (run_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        run_d = 1'b0;
      end
      if (div_q) begin
        // With b=0 every trial subtract succeeds, so the quotient becomes all
        // ones and the dividend shifts whole into the remainder register.
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
        if (rshift >= {1'b0, b_q}) begin
          hi_d    = WIDTH'(rshift - {1'b0, b_q});
          lo_d[0] = 1'b1;
        end else begin
          hi_d = rshift[WIDTH-1:0];
        end
      end else begin
        hi_d = msum[WIDTH:1];
        lo_d = {msum[0], lo_q[WIDTH-1:1]};
      end
    end
  end

  // Engine state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      div_q <= 1'b0;
      dz_q  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      dz_q  <= dz_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
    end
  end

  assign done = last;
  assign lo   = lo_q;
  assign hi   = hi_q;
  assign dz   = dz_q;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : Execute stage of the 8-bit accumulator pipeline. Single-cycle
//               ALU ops register in one cycle; MUL/DIV hand off to the
//               iterative engine and stall upstream until the result is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int ITER  = WIDTH            // must equal WIDTH
) (
  input  logic             clk,
  input  logic             rst,          // synchronous, active-low
  input  logic             in_valid,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] data_in,
  input  logic             mem_we_in,
  input  logic             acc_we_in,
  input  logic             acc_control_in,
  input  logic             flush,
  output logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] aux_out,
  output logic [WIDTH-1:0] acc_out,
  output logic [WIDTH-1:0] data_out,
  output logic             mem_we_out,
  output logic             acc_we_out,
  output logic             acc_control_out,
  output logic             carry_out,
  output logic             zero_out,
  output logic             dz_out
);

  ex_state_t        state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_result_q, alu_result_d;
  logic [WIDTH-1:0] aux_q, aux_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             mem_we_q, mem_we_d;
  logic             acc_we_q, acc_we_d;
  logic             acc_control_q, acc_control_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             dz_q, dz_d;
  // Instruction fields held for the duration of a MUL/DIV.
  logic [WIDTH-1:0] lat_acc_q, lat_acc_d;
  logic [WIDTH-1:0] lat_data_q, lat_data_d;
  logic             lat_mem_we_q, lat_mem_we_d;
  logic             lat_acc_we_q, lat_acc_we_d;
  logic             lat_acc_control_q, lat_acc_control_d;
  logic             lat_is_div_q, lat_is_div_d;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             eng_start;
  logic             eng_done;
  logic [WIDTH-1:0] eng_lo;
  logic [WIDTH-1:0] eng_hi;
  logic             eng_dz;

  mul_div_iter #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_mul_div_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (eng_start),
    .abort  (flush),
    .is_div (opcode == ALU_DIV),
    .a      (operand_a),
    .b      (operand_b),
    .done   (eng_done),
    .lo     (eng_lo),
    .hi     (eng_hi),
    .dz     (eng_dz)
  );

  // Single-cycle ALU; reserved codes fall through to PASSA.
  always_comb begin
    sum_ext   = {1'b0, operand_a} + {1'b0, operand_b};
    dif_ext   = {1'b0, operand_a} - {1'b0, operand_b};
    alu_res   = operand_a;
    alu_carry = 1'b0;
    case (opcode)
      ALU_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      ALU_SUB: begin
        alu_res   = dif_ext[WIDTH-1:0];
        alu_carry = dif_ext[WIDTH];          // borrow: a < b
      end
      ALU_AND:   alu_res = operand_a & operand_b;
      ALU_OR:    alu_res = operand_a | operand_b;
      ALU_XOR:   alu_res = operand_a ^ operand_b;
      ALU_NOT:   alu_res = ~operand_a;
      ALU_SHL: begin
        alu_res   = {operand_a[WIDTH-2:0], 1'b0};
        alu_carry = operand_a[WIDTH-1];
      end
      ALU_SHR: begin
        alu_res   = {1'b0, operand_a[WIDTH-1:1]};
        alu_carry = operand_a[0];
      end
      ALU_PASSB: alu_res = operand_b;
      default:   alu_res = operand_a;
    endcase
  end

  // Upstream holds while a MUL/DIV is being accepted or is iterating.
  assign stall = rst && !flush &&
                 (((state_q == IDLE) && in_valid && is_mul_div(opcode)) ||
                  (state_q == BUSY));

  // Next-state and output-register logic; every default is a bubble.
  always_comb begin
    state_d           = state_q;
    eng_start         = 1'b0;
    out_valid_d       = 1'b0;
    mem_we_d          = 1'b0;
    acc_we_d          = 1'b0;
    acc_control_d     = 1'b0;
    carry_d           = 1'b0;
    zero_d            = 1'b0;
    dz_d              = 1'b0;
    alu_result_d      = alu_result_q;
    aux_d             = aux_q;
    acc_d             = acc_q;
    data_d            = data_q;
    lat_acc_d         = lat_acc_q;
    lat_data_d        = lat_data_q;
    lat_mem_we_d      = lat_mem_we_q;
    lat_acc_we_d      = lat_acc_we_q;
    lat_acc_control_d = lat_acc_control_q;
    lat_is_div_d      = lat_is_div_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_mul_div(opcode)) begin
              eng_start         = 1'b1;
              state_d           = BUSY;
              lat_acc_d         = operand_a;
              lat_data_d        = data_in;
              lat_mem_we_d      = mem_we_in;
              lat_acc_we_d      = acc_we_in;
              lat_acc_control_d = acc_control_in;
              lat_is_div_d      = (opcode == ALU_DIV);
            end else begin
              out_valid_d   = 1'b1;
              alu_result_d  = alu_res;
              aux_d         = '0;
              carry_d       = alu_carry;
              zero_d        = (alu_res == '0);
              acc_d         = operand_a;
              data_d        = data_in;
              mem_we_d      = mem_we_in && !is_reserved(opcode);
              acc_we_d      = acc_we_in && !is_reserved(opcode);
              acc_control_d = acc_control_in;
            end
          end
        end
        BUSY: begin
          if (eng_done) begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d       = IDLE;
          out_valid_d   = 1'b1;
          alu_result_d  = eng_lo;
          aux_d         = eng_hi;
          carry_d       = !lat_is_div_q && (eng_hi != '0);
          zero_d        = (eng_lo == '0);
          dz_d          = eng_dz;
          acc_d         = lat_acc_q;
          data_d        = lat_data_q;
          mem_we_d      = lat_mem_we_q;
          acc_we_d      = lat_acc_we_q && !eng_dz;
          acc_control_d = lat_acc_control_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and EX/WB output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= IDLE;
      out_valid_q       <= 1'b0;
      alu_result_q      <= '0;
      aux_q             <= '0;
      acc_q             <= '0;
      data_q            <= '0;
      mem_we_q          <= 1'b0;
      acc_we_q          <= 1'b0;
      acc_control_q     <= 1'b0;
      carry_q           <= 1'b0;
      zero_q            <= 1'b0;
      dz_q              <= 1'b0;
      lat_acc_q         <= '0;
      lat_data_q        <= '0;
      lat_mem_we_q      <= 1'b0;
      lat_acc_we_q      <= 1'b0;
      lat_acc_control_q <= 1'b0;
      lat_is_div_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      out_valid_q       <= out_valid_d;
      alu_result_q      <= alu_result_d;
      aux_q             <= aux_d;
      acc_q             <= acc_d;
      data_q            <= data_d;
      mem_we_q          <= mem_we_d;
      acc_we_q          <= acc_we_d;
      acc_control_q     <= acc_control_d;
      carry_q           <= carry_d;
      zero_q            <= zero_d;
      dz_q              <= dz_d;
      lat_acc_q         <= lat_acc_d;
      lat_data_q        <= lat_data_d;
      lat_mem_we_q      <= lat_mem_we_d;
      lat_acc_we_q      <= lat_acc_we_d;
      lat_acc_control_q <= lat_acc_control_d;
      lat_is_div_q      <= lat_is_div_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign alu_result_out  = alu_result_q;
  assign aux_out         = aux_q;
  assign acc_out         = acc_q;
  assign data_out        = data_q;
  assign mem_we_out      = mem_we_q;
  assign acc_we_out      = acc_we_q;
  assign acc_control_out = acc_control_q;
  assign carry_out       = carry_q;
  assign zero_out        = zero_q;
  assign dz_out          = dz_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage: directed vector table,
//               randomized ops against an arithmetic reference model, and
//               hand-written flush / reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [3:0]   opcode;
  logic [W-1:0] operand_a, operand_b, data_in;
  logic         mem_we_in, acc_we_in, acc_control_in, flush;
  logic         stall, out_valid;
  logic [W-1:0] alu_result_out, aux_out, acc_out, data_out;
  logic         mem_we_out, acc_we_out, acc_control_out;
  logic         carry_out, zero_out, dz_out;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(W), .ITER(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .opcode          (opcode),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .data_in         (data_in),
    .mem_we_in       (mem_we_in),
    .acc_we_in       (acc_we_in),
    .acc_control_in  (acc_control_in),
    .flush           (flush),
    .stall           (stall),
    .out_valid       (out_valid),
    .alu_result_out  (alu_result_out),
    .aux_out         (aux_out),
    .acc_out         (acc_out),
    .data_out        (data_out),
    .mem_we_out      (mem_we_out),
    .acc_we_out      (acc_we_out),
    .acc_control_out (acc_control_out),
    .carry_out       (carry_out),
    .zero_out        (zero_out),
    .dz_out          (dz_out)
  );

  typedef struct {
    int op; int a; int b; int d;
    bit mwe; bit awe; bit actl;
  } stim_t;

  typedef struct {
    int res; int aux;
    bit carry; bit zero; bit dz; bit mwe; bit awe; bit actl;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from the opcode definitions, in plain integer math.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    int   p;
    e.res = 0; e.aux = 0; e.carry = 0; e.dz = 0;
    e.mwe = s.mwe; e.awe = s.awe; e.actl = s.actl;
    case (s.op)
      0:  begin p = s.a + s.b; e.res = p % 256; e.carry = (p > 255); end
      1:  begin e.res = (s.a - s.b + 256) % 256; e.carry = (s.a < s.b); end
      2:  e.res = s.a & s.b;
      3:  e.res = s.a | s.b;
      4:  e.res = s.a ^ s.b;
      5:  e.res = 255 - s.a;
      6:  begin e.res = (s.a * 2) % 256; e.carry = (s.a >= 128); end
      7:  begin e.res = s.a / 2; e.carry = ((s.a % 2) == 1); end
      8:  e.res = s.b;
      9:  e.res = s.a;
      10: begin p = s.a * s.b; e.res = p % 256; e.aux = p / 256; e.carry = (e.aux != 0); end
      11: begin
        if (s.b == 0) begin
          e.res = 255; e.aux = s.a; e.dz = 1; e.awe = 0;
        end else begin
          e.res = s.a / s.b; e.aux = s.a % s.b;
        end
      end
      default: begin e.res = s.a; e.mwe = 0; e.awe = 0; end
    endcase
    e.zero = (e.res == 0);
    return e;
  endfunction

  function automatic vec_t mk(input int op, input int a, input int b, input int res,
                              input int aux, input bit c, input bit z, input bit dz,
                              input bit mwe, input bit awe);
    vec_t v;
    v.s.op = op; v.s.a = a; v.s.b = b; v.s.d = 'h5A;
    v.s.mwe = 1; v.s.awe = 1; v.s.actl = 1;
    v.e.res = res; v.e.aux = aux; v.e.carry = c; v.e.zero = z; v.e.dz = dz;
    v.e.mwe = mwe; v.e.awe = awe; v.e.actl = 1;
    return v;
  endfunction

  task automatic drive(input stim_t s);
    opcode         = s.op[3:0];
    operand_a      = s.a[W-1:0];
    operand_b      = s.b[W-1:0];
    data_in        = s.d[W-1:0];
    mem_we_in      = s.mwe;
    acc_we_in      = s.awe;
    acc_control_in = s.actl;
  endtask

  // Present one instruction, wait for its result, check latency and outputs.
  task automatic run_op(input stim_t s, input exp_t e, input string tag);
    int lat, stalls, exp_lat;
    bit got, bubble_ok;
    exp_lat   = (s.op == 10 || s.op == 11) ? 10 : 1;
    lat = 0; stalls = 0; got = 0; bubble_ok = 1;
    in_valid  = 1'b1;
    drive(s);
    for (int k = 1; k <= 20 && !got; k++) begin
      #1;
      if (stall) stalls++;
      @(posedge clk); #1;
      lat = k;
      if (out_valid) begin
        got = 1;
      end else begin
        if (mem_we_out || acc_we_out || acc_control_out) bubble_ok = 0;
        if (stall) begin
          opcode    = 4'($urandom_range(15));
          operand_a = 8'($urandom);
          operand_b = 8'($urandom);
          data_in   = 8'($urandom);
        end else begin
          drive(s);
        end
      end
    end
    in_valid = 1'b0;
    check({tag, " out_valid seen"}, 32'(got), 32'd1);
    check({tag, " latency"},        32'(lat), 32'(exp_lat));
    check({tag, " stall cycles"},   32'(stalls), 32'(exp_lat - 1));
    check({tag, " bubble ctrl"},    32'(bubble_ok), 32'd1);
    check({tag, " alu_result"},     32'(alu_result_out), 32'(e.res));
    check({tag, " aux"},            32'(aux_out), 32'(e.aux));
    check({tag, " carry"},          32'(carry_out), 32'(e.carry));
    check({tag, " zero"},           32'(zero_out), 32'(e.zero));
    check({tag, " dz"},             32'(dz_out), 32'(e.dz));
    check({tag, " acc_out"},        32'(acc_out), 32'(s.a));
    check({tag, " data_out"},       32'(data_out), 32'(s.d));
    check({tag, " mem_we"},         32'(mem_we_out), 32'(e.mwe));
    check({tag, " acc_we"},         32'(acc_we_out), 32'(e.awe));
    check({tag, " acc_control"},    32'(acc_control_out), 32'(e.actl));
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({out_valid, alu_result_out, aux_out, acc_out, mem_we_out, acc_we_out,
                acc_control_out, carry_out, zero_out, dz_out}) | 32'(data_out);
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tab[17];
    stim_t s;
    int    ghosts;

    tab[0]  = mk(0,  'h7F, 'h01, 'h80, 0,    0, 0, 0, 1, 1);
    tab[1]  = mk(0,  'hFF, 'h01, 'h00, 0,    1, 1, 0, 1, 1);
    tab[2]  = mk(1,  'h03, 'h05, 'hFE, 0,    1, 0, 0, 1, 1);
    tab[3]  = mk(1,  'h05, 'h05, 'h00, 0,    0, 1, 0, 1, 1);
    tab[4]  = mk(6,  'h81, 'h00, 'h02, 0,    1, 0, 0, 1, 1);
    tab[5]  = mk(7,  'h81, 'h00, 'h40, 0,    1, 0, 0, 1, 1);
    tab[6]  = mk(2,  'hF0, 'h3C, 'h30, 0,    0, 0, 0, 1, 1);
    tab[7]  = mk(3,  'hF0, 'h3C, 'hFC, 0,    0, 0, 0, 1, 1);
    tab[8]  = mk(4,  'hF0, 'h3C, 'hCC, 0,    0, 0, 0, 1, 1);
    tab[9]  = mk(5,  'h0F, 'h00, 'hF0, 0,    0, 0, 0, 1, 1);
    tab[10] = mk(8,  'h00, 'h55, 'h55, 0,    0, 0, 0, 1, 1);
    tab[11] = mk(9,  'hAA, 'h00, 'hAA, 0,    0, 0, 0, 1, 1);
    tab[12] = mk(13, 'h00, 'h77, 'h00, 0,    0, 1, 0, 0, 0);
    tab[13] = mk(10, 'h0F, 'h11, 'hFF, 'h00, 0, 0, 0, 1, 1);
    tab[14] = mk(10, 'hFF, 'hFF, 'h01, 'hFE, 1, 0, 0, 1, 1);
    tab[15] = mk(11, 'h64, 'h07, 'h0E, 'h02, 0, 0, 0, 1, 1);
    tab[16] = mk(11, 'h10, 'h00, 'hFF, 'h10, 0, 0, 1, 1, 0);

    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    opcode = 4'd0; operand_a = '0; operand_b = '0; data_in = '0;
    mem_we_in = 1'b0; acc_we_in = 1'b0; acc_control_in = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", all_outs(), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle bubble", 32'(out_valid), 32'd0);

    // Directed vectors
    foreach (tab[i]) run_op(tab[i].s, tab[i].e, $sformatf("vec%0d", i));

    // Randomized ops with occasional idle gaps
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(4) == 0) begin
        in_valid = 1'b0;
        opcode   = 4'($urandom_range(15));
        #1;
        check("gap stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        check("gap bubble", 32'({out_valid, mem_we_out, acc_we_out, acc_control_out}), 32'd0);
      end
      s.op   = $urandom_range(15);
      s.a    = $urandom_range(255);
      s.b    = ($urandom_range(7) == 0) ? 0 : $urandom_range(255);
      s.d    = $urandom_range(255);
      s.mwe  = 1'($urandom_range(1));
      s.awe  = 1'($urandom_range(1));
      s.actl = 1'($urandom_range(1));
      run_op(s, model(s), $sformatf("rnd%0d op%0d", n, s.op));
    end

    // Flush in the 4th BUSY cycle of a MUL
    s.op = 10; s.a = 'h0F; s.b = 'h11; s.d = 'h33; s.mwe = 1; s.awe = 1; s.actl = 1;
    in_valid = 1'b1;
    drive(s);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    check("flush stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush bubble", 32'({out_valid, mem_we_out, acc_we_out, acc_control_out}), 32'd0);
    s.op = 0; s.a = 'h12; s.b = 'h34; s.d = 'h44;
    run_op(s, model(s), "post-flush add");
    ghosts = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) ghosts++;
    end
    check("no result after flush", 32'(ghosts), 32'd0);

    // Reset in the middle of a DIV with all control bits set
    s.op = 11; s.a = 'h64; s.b = 'h07; s.d = 'hC3; s.mwe = 1; s.awe = 1; s.actl = 1;
    in_valid = 1'b1;
    drive(s);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset-mid stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("reset-mid outputs", all_outs(), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("post-reset bubble", 32'(out_valid), 32'd0);
    s.op = 0; s.a = 'h01; s.b = 'h02; s.d = 'h10; s.mwe = 0; s.awe = 1; s.actl = 0;
    run_op(s, model(s), "post-reset add");
    s.op = 10; s.a = 'h0F; s.b = 'h11;
    run_op(s, model(s), "post-reset mul");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
